// File: rtl/shift_pkg.sv
// Shared widths and shift opcodes for the shifter arbiter and its datapath.
package shift_pkg;

    localparam int XLEN  = 32;
    localparam int SHW   = 5;
    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        SHIFT_SRL  = 2'b00,
        SHIFT_SLL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_RSVD = 2'b11
    } shift_op_e;

endpackage

// File: rtl/shifter_arbiter_shifter.sv
// Combinational barrel shifter: logical right, logical left and arithmetic right.
module shifter_arbiter_shifter
    import shift_pkg::shift_op_e;
    import shift_pkg::SHIFT_SRL;
    import shift_pkg::SHIFT_SLL;
    import shift_pkg::SHIFT_SRA;
#(
    parameter int XLEN = shift_pkg::XLEN,
    parameter int SHW  = shift_pkg::SHW
) (
    input  logic [XLEN-1:0] a,
    input  logic [SHW-1:0]  shamt,
    input  shift_op_e       op,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            SHIFT_SRL: y = a >> shamt;
            SHIFT_SLL: y = a << shamt;
            SHIFT_SRA: y = $unsigned($signed(a) >>> shamt);
            default:   y = a;
        endcase
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one shifter between two requesters, with a
// single registered result slot carrying requester id, tag and error flag.
module shifter_arbiter
    import shift_pkg::shift_op_e;
    import shift_pkg::SHIFT_RSVD;
#(
    parameter int XLEN  = shift_pkg::XLEN,
    parameter int SHW   = shift_pkg::SHW,
    parameter int TAG_W = shift_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic [1:0]       req0_type,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [SHW-1:0]   req1_shamt,
    input  logic [1:0]       req1_type,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic             res_id,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);

    logic             rr_q;
    logic             can_accept;
    logic [1:0]       grant;
    logic             accept;
    logic             sel;
    logic [XLEN-1:0]  sel_a;
    logic [SHW-1:0]   sel_shamt;
    shift_op_e        sel_op;
    logic [TAG_W-1:0] sel_tag;
    logic [XLEN-1:0]  shift_y;
    logic             sel_rsvd;

    assign can_accept = !res_valid || res_ready;

    // On a tie rr_q picks the winner; a lone requester always wins.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = rst_n ? (grant & {2{can_accept}}) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign sel       = grant[1];

    assign sel_a     = sel ? req1_a     : req0_a;
    assign sel_shamt = sel ? req1_shamt : req0_shamt;
    assign sel_op    = shift_op_e'(sel ? req1_type : req0_type);
    assign sel_tag   = sel ? req1_tag   : req0_tag;
    assign sel_rsvd  = (sel_op == SHIFT_RSVD);

    shifter_arbiter_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .a     (sel_a),
        .shamt (sel_shamt),
        .op    (sel_op),
        .y     (shift_y)
    );

    // Result slot reloads on every accept; drains when the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else if (accept) begin
            rr_q      <= ~sel;
            res_valid <= 1'b1;
            res_data  <= sel_rsvd ? sel_a : shift_y;
            res_id    <= sel;
            res_tag   <= sel_tag;
            res_err   <= sel_rsvd;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed and model-checked bench for the two-requester shifter arbiter.
module tb_shifter_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req1_a;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_type, req1_type;
    logic [3:0]  req0_tag, req1_tag;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_id;
    logic [3:0]  res_tag;
    logic        res_err;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    shifter_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req0_type  (req0_type),
        .req0_tag   (req0_tag),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .req1_type  (req1_type),
        .req1_tag   (req1_tag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_tag    (res_tag),
        .res_err    (res_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] ty, input logic [3:0] tg);
        req0_a = a; req0_shamt = sh; req0_type = ty; req0_tag = tg;
    endtask

    task automatic drive1(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] ty, input logic [3:0] tg);
        req1_a = a; req1_shamt = sh; req1_type = ty; req1_tag = tg;
    endtask

    // Bit-by-bit reference shift, written independently of the RTL operators.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int sh, input logic [1:0] ty);
        logic [31:0] r;
        r = a;
        for (int j = 0; j < 32; j++) begin
            case (ty)
                2'b00:   r[j] = (j + sh < 32) ? a[j + sh] : 1'b0;
                2'b01:   r[j] = (j >= sh) ? a[j - sh] : 1'b0;
                2'b10:   r[j] = (j + sh < 32) ? a[j + sh] : a[31];
                default: r[j] = a[j];
            endcase
        end
        return r;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; res_ready = 1'b0;
        drive0(32'h0, 5'd0, 2'b00, 4'd0);
        drive1(32'h0, 5'd0, 2'b00, 4'd0);
        repeat (2) @(negedge clk);
        compared++;
        if (req_ready !== 2'b00 || res_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_initial: req_ready=%b res_valid=%b expected 00/0", req_ready, res_valid);
        end
        rst_n = 1'b1;
        req_valid = 2'b10;
        drive1(32'h0000_0001, 5'd4, 2'b01, 4'd7);
        tick();
        req_valid = 2'b11;
        compared++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_0010 || res_id !== 1'b1 || res_tag !== 4'd7) begin
            mismatched++;
            $display("[TB] FAIL reset_preload: valid=%b data=%h id=%b tag=%h expected 1/00000010/1/7", res_valid, res_data, res_id, res_tag);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({res_valid, res_data, res_id, res_tag, res_err} !== 39'd0 || req_ready !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_async: valid=%b data=%h id=%b tag=%h err=%b ready=%b expected all zero", res_valid, res_data, res_id, res_tag, res_err, req_ready);
        end
        tick();
        compared++;
        if (res_valid !== 1'b0 || req_ready !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_held: valid=%b ready=%b expected 0/00", res_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        req_valid = 2'b01;
        drive0(32'h8000_0010, 5'd4, 2'b10, 4'd3);
        #1;
        compared++;
        if (req_ready !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL single_ready: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        compared++;
        if (res_valid !== 1'b1 || res_data !== 32'hF800_0001 || res_id !== 1'b0 || res_tag !== 4'd3 || res_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_result: valid=%b data=%h id=%b tag=%h err=%b expected 1/f8000001/0/3/0", res_valid, res_data, res_id, res_tag, res_err);
        end
        tick();
        compared++;
        if (res_valid !== 1'b0 || res_data !== 32'hF800_0001) begin
            mismatched++;
            $display("[TB] FAIL single_drain: valid=%b data=%h expected 0/f8000001", res_valid, res_data);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] exp_dat [2] = '{32'h0000_000F, 32'h8000_0000};
        logic [3:0]  exp_tag [2] = '{4'd1, 4'd2};
        pulse_reset();
        res_ready = 1'b1;
        drive0(32'h0000_00F0, 5'd4, 2'b00, 4'd1);
        drive1(32'h0000_0001, 5'd31, 2'b01, 4'd2);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            compared++;
            if (req_ready !== exp_rdy[k]) begin
                mismatched++;
                $display("[TB] FAIL contend_grant%0d: got %b expected %b", k, req_ready, exp_rdy[k]);
            end
            tick();
            compared++;
            if (res_valid !== 1'b1 || res_id !== k[0] || res_data !== exp_dat[k%2] || res_tag !== exp_tag[k%2]) begin
                mismatched++;
                $display("[TB] FAIL contend_result%0d: valid=%b id=%b data=%h tag=%h expected 1/%b/%h/%h",
                         k, res_valid, res_id, res_data, res_tag, k[0], exp_dat[k%2], exp_tag[k%2]);
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        req_valid = 2'b01;
        drive0(32'h0000_00FF, 5'd8, 2'b01, 4'd5);
        tick();
        req_valid = 2'b10;
        drive1(32'hFFFF_0000, 5'd16, 2'b00, 4'd6);
        for (int k = 0; k < 3; k++) begin
            #1;
            compared++;
            if (req_ready !== 2'b00) begin
                mismatched++;
                $display("[TB] FAIL bp_ready%0d: got %b expected 00", k, req_ready);
            end
            tick();
            compared++;
            if (res_valid !== 1'b1 || res_data !== 32'h0000_FF00 || res_id !== 1'b0 || res_tag !== 4'd5) begin
                mismatched++;
                $display("[TB] FAIL bp_hold%0d: valid=%b data=%h id=%b tag=%h expected 1/0000ff00/0/5", k, res_valid, res_data, res_id, res_tag);
            end
        end
        res_ready = 1'b1;
        #1;
        compared++;
        if (req_ready !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL bp_release_ready: got %b expected 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        compared++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_FFFF || res_id !== 1'b1 || res_tag !== 4'd6) begin
            mismatched++;
            $display("[TB] FAIL bp_reload: valid=%b data=%h id=%b tag=%h expected 1/0000ffff/1/6", res_valid, res_data, res_id, res_tag);
        end
        tick();
    endtask

    task automatic test_reserved();
        res_ready = 1'b1;
        req_valid = 2'b10;
        drive1(32'h1234_5678, 5'd7, 2'b11, 4'd9);
        tick();
        req_valid = 2'b00;
        compared++;
        if (res_valid !== 1'b1 || res_data !== 32'h1234_5678 || res_err !== 1'b1 || res_id !== 1'b1 || res_tag !== 4'd9) begin
            mismatched++;
            $display("[TB] FAIL reserved: valid=%b data=%h err=%b id=%b tag=%h expected 1/12345678/1/1/9", res_valid, res_data, res_err, res_id, res_tag);
        end
        tick();
    endtask

    task automatic test_edges();
        logic [31:0] va [4] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [4:0]  vs [4] = '{5'd0, 5'd31, 5'd31, 5'd31};
        logic [1:0]  vt [4] = '{2'b00, 2'b00, 2'b10, 2'b10};
        logic [31:0] ve [4] = '{32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b01;
            drive0(va[k], vs[k], vt[k], 4'(k));
            tick();
            compared++;
            if (res_valid !== 1'b1 || res_data !== ve[k] || res_err !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL edge%0d: valid=%b data=%h err=%b expected 1/%h/0", k, res_valid, res_data, res_err, ve[k]);
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    // Random traffic against a bench-side arbiter/result model.
    task automatic test_random();
        logic        m_valid, m_id, m_err, m_rr, m_can;
        logic [31:0] m_data;
        logic [3:0]  m_tag;
        logic [1:0]  pend, m_grant;
        logic [3:0]  next_tag [2];
        int          errs;
        pulse_reset();
        m_valid = 0; m_id = 0; m_err = 0; m_rr = 0; m_data = 0; m_tag = 0;
        pend = 2'b00; next_tag[0] = 0; next_tag[1] = 0; errs = 0;
        req_valid = 2'b00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!pend[0] && $urandom_range(0, 3) != 0) begin
                drive0($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), next_tag[0]);
                next_tag[0] = next_tag[0] + 4'd1;
                pend[0] = 1'b1;
            end
            if (!pend[1] && $urandom_range(0, 3) != 0) begin
                drive1($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), next_tag[1]);
                next_tag[1] = next_tag[1] + 4'd1;
                pend[1] = 1'b1;
            end
            req_valid = pend;
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            m_can = !m_valid || res_ready;
            if (pend == 2'b11) m_grant = m_rr ? 2'b10 : 2'b01;
            else               m_grant = pend;
            if (!m_can) m_grant = 2'b00;
            compared++;
            if (req_ready !== m_grant) begin
                mismatched++;
                if (errs++ < 5) $display("[TB] FAIL rand_grant cyc%0d: got %b expected %b", cyc, req_ready, m_grant);
            end
            tick();
            if (m_grant != 2'b00) begin
                m_id    = m_grant[1];
                m_data  = m_id ? ref_shift(req1_a, int'(req1_shamt), req1_type) : ref_shift(req0_a, int'(req0_shamt), req0_type);
                m_tag   = m_id ? req1_tag : req0_tag;
                m_err   = m_id ? (req1_type == 2'b11) : (req0_type == 2'b11);
                m_valid = 1'b1;
                m_rr    = ~m_id;
                pend[m_id] = 1'b0;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
            compared++;
            if (res_valid !== m_valid || (m_valid && {res_data, res_id, res_tag, res_err} !== {m_data, m_id, m_tag, m_err})) begin
                mismatched++;
                if (errs++ < 5)
                    $display("[TB] FAIL rand_result cyc%0d: valid=%b data=%h id=%b tag=%h err=%b expected %b/%h/%b/%h/%b",
                             cyc, res_valid, res_data, res_id, res_tag, res_err, m_valid, m_data, m_id, m_tag, m_err);
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reserved();
        test_edges();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
